// File: rtl/wshb_sdram_arbiter.sv
// Two-master Wishbone arbiter that shares one SDRAM slave port. Ownership is
// round-robin, bursts are never split, and a watchdog aborts a stalled owner.
module wshb_sdram_arbiter #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_W-1:0]       m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_W-1:0]       m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,
  input  logic                    s_ack,
  input  logic                    s_err,
  output logic [1:0]              grant
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t          state, state_nxt;
  logic            last;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            own_cyc, own_stb, timeout, active;

  // Handshake: a beat completes when the owner holds cyc&stb and the slave
  // answers with ack or err in the same cycle; only the owner sees ack/err.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (state == GNT0) begin
      own_cyc = m0_cyc;
      own_stb = m0_stb;
    end else if (state == GNT1) begin
      own_cyc = m1_cyc;
      own_stb = m1_stb;
    end
    // A slave ack/err in the boundary cycle wins over the watchdog.
    timeout = (state != IDLE) && own_stb && !s_ack && !s_err &&
              (cnt == CW'(TIMEOUT));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc)      state_nxt = GNT0;
        else if (m1_cyc)      state_nxt = GNT1;
      end
      GNT0: begin
        if (!(m0_cyc && !timeout)) state_nxt = m1_cyc ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!(m1_cyc && !timeout)) state_nxt = m0_cyc ? GNT0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    if (state == IDLE || state_nxt != state || !own_stb || s_ack || s_err)
      cnt_nxt = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state != IDLE && state_nxt != state) last <= (state == GNT1);
    end
  end

  assign grant  = {state == GNT1, state == GNT0};
  // Outputs are gated by reset so nothing reaches the slave or masters mid-reset.
  assign active = !sys_rst && (state != IDLE);

  always_comb begin
    s_cyc    = active && own_cyc && !timeout;
    s_stb    = active && own_stb && !timeout;
    s_we     = (state == GNT1) ? m1_we     : m0_we;
    s_adr    = (state == GNT1) ? m1_adr    : m0_adr;
    s_dat_ms = (state == GNT1) ? m1_dat_ms : m0_dat_ms;
    s_sel    = (state == GNT1) ? m1_sel    : m0_sel;
    m0_ack   = !sys_rst && (state == GNT0) && s_ack;
    m1_ack   = !sys_rst && (state == GNT1) && s_ack;
    m0_err   = !sys_rst && (state == GNT0) && (s_err || timeout);
    m1_err   = !sys_rst && (state == GNT1) && (s_err || timeout);
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Directed bench for wshb_sdram_arbiter (TIMEOUT=8): single master, contention,
// burst hold, watchdog abort, ack on the watchdog boundary and reset mid-burst.
module tb_wshb_sdram_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm, m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack, s_err;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  wshb_sdram_arbiter #(.DATA_BYTES(4), .ADDR_W(32), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_dat_sm(m0_dat_sm),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_dat_sm(m1_dat_sm),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_dat_sm(s_dat_sm),
    .s_ack(s_ack), .s_err(s_err), .grant(grant)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    drop_all();
    m0_we = 1'b0; m1_we = 1'b1; m0_sel = 4'hf; m1_sel = 4'h3;
    m0_adr = '0; m1_adr = '0; m0_dat_ms = 32'h1111_0000; m1_dat_ms = 32'h2222_0000;
    s_dat_sm = 32'h0;

    // Reset with a master and the slave both active: nothing may pass.
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    tick();
    settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    tick();
    sys_rst = 1'b0;
    drop_all();
    tick();

    // Single master: 4-word read at 0x100..0x10C.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
    settle();
    chk("lat_s_cyc", s_cyc, 1'b0);
    chk("lat_grant", grant, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) begin
      m0_adr = 32'h100 + 32'(4 * i);
      s_ack = 1'b1;
      s_dat_sm = 32'hA000 + 32'(i);
      settle();
      chk("rd_grant", grant, 2'b01);
      chk("rd_s_cyc", s_cyc, 1'b1);
      chk("rd_s_adr", s_adr, 32'h100 + 32'(4 * i));
      chk("rd_s_sel", s_sel, 4'hf);
      chk("rd_s_we", s_we, 1'b0);
      chk("rd_m0_ack", m0_ack, 1'b1);
      chk("rd_m0_dat", m0_dat_sm, 32'hA000 + 32'(i));
      chk("rd_m1_ack", m1_ack, 1'b0);
      chk("rd_m1_dat", m1_dat_sm, 32'hA000 + 32'(i));
      tick();
    end
    drop_all();
    settle();
    chk("rd_end_s_cyc", s_cyc, 1'b0);
    tick();
    settle();
    chk("rd_idle_grant", grant, 2'b00);

    // Contention right after reset: master 0 first, direct handover to 1.
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h200;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h300; s_ack = 1'b1;
    tick();
    settle();
    chk("ct_grant0", grant, 2'b01);
    chk("ct_s_adr0", s_adr, 32'h200);
    chk("ct_m0_ack", m0_ack, 1'b1);
    chk("ct_m1_ack", m1_ack, 1'b0);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    tick();
    settle();
    chk("ct_handover", grant, 2'b10);
    chk("ct_s_adr1", s_adr, 32'h300);
    chk("ct_s_we1", s_we, 1'b1);
    chk("ct_s_dat1", s_dat_ms, 32'h2222_0000);
    tick();
    drop_all();
    tick();
    settle();
    chk("ct_idle1", grant, 2'b00);
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    settle();
    chk("ct_rr_after_m1", grant, 2'b01);
    tick();
    drop_all();
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    settle();
    chk("ct_rr_after_m0", grant, 2'b10);
    tick();
    drop_all();
    tick();

    // Burst hold: 16 acked beats for master 1 while master 0 waits.
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h400; s_ack = 1'b1;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("bh_grant", grant, 2'b10);
      chk("bh_m1_ack", m1_ack, 1'b1);
      chk("bh_m0_ack", m0_ack, 1'b0);
      tick();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    settle();
    chk("bh_last_grant", grant, 2'b10);
    tick();
    settle();
    chk("bh_switch", grant, 2'b01);
    drop_all();
    tick();
    tick();

    // Watchdog: slave never answers master 0; master 1 waits from cycle 5.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h500;
    tick();
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) begin
        m1_cyc = 1'b1; m1_stb = 1'b1;
      end
      settle();
      if (k < 9) begin
        chk("to_no_err", m0_err, 1'b0);
        chk("to_s_cyc", s_cyc, 1'b1);
      end else begin
        chk("to_err", m0_err, 1'b1);
        chk("to_s_cyc_cut", s_cyc, 1'b0);
        chk("to_s_stb_cut", s_stb, 1'b0);
        chk("to_grant_hold", grant, 2'b01);
        chk("to_m1_err", m1_err, 1'b0);
      end
      tick();
    end
    settle();
    chk("to_handover", grant, 2'b10);
    chk("to_err_gone", m0_err, 1'b0);
    drop_all();
    tick();
    settle();
    chk("to_idle", grant, 2'b00);
    tick();

    // Ack exactly in the boundary cycle: ack wins, counter restarts.
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk("bd_wait_err", m0_err, 1'b0);
      tick();
    end
    s_ack = 1'b1;
    settle();
    chk("bd_ack", m0_ack, 1'b1);
    chk("bd_err", m0_err, 1'b0);
    chk("bd_s_cyc", s_cyc, 1'b1);
    tick();
    s_ack = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      settle();
      chk("bd_grant", grant, 2'b01);
      chk("bd_restart_err", m0_err, (j == 9) ? 1'b1 : 1'b0);
      tick();
    end
    drop_all();
    settle();
    chk("bd_idle", grant, 2'b00);
    tick();

    // Reset pulse in the middle of a master 1 burst.
    m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
    tick();
    settle();
    chk("rb_grant", grant, 2'b10);
    chk("rb_ack", m1_ack, 1'b1);
    tick();
    sys_rst = 1'b1;
    settle();
    chk("rb_rst_ack", m1_ack, 1'b0);
    chk("rb_rst_s_cyc", s_cyc, 1'b0);
    tick();
    sys_rst = 1'b0;
    settle();
    chk("rb_post_grant", grant, 2'b00);
    chk("rb_post_s_cyc", s_cyc, 1'b0);
    chk("rb_post_ack", m1_ack, 1'b0);
    tick();
    settle();
    chk("rb_regrant", grant, 2'b10);
    chk("rb_regrant_ack", m1_ack, 1'b1);
    drop_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wshb_sdram_arbiter.md
WSHB_SDRAM_ARBITER -- requirements
Module: wshb_sdram_arbiter

Interface
REQ-001 Parameter DATA_BYTES, default 4: Wishbone data width in bytes; data width is 8*DATA_BYTES, sel width is DATA_BYTES.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter TIMEOUT, default 255: maximum stb-without-ack cycles before abort; legal range 1..65535.
REQ-004 sys_clk  in  1  system clock (100 MHz); single clock domain.
REQ-005 sys_rst  in  1  synchronous, active-high reset.
REQ-006 mN_cyc, mN_stb, mN_we  in  1 each  Wishbone cycle, strobe and write-enable from master N (N=0 video reader, N=1 writer).
REQ-007 mN_adr  in  ADDR_W  address from master N.
REQ-008 mN_dat_ms  in  8*DATA_BYTES  write data from master N.
REQ-009 mN_sel  in  DATA_BYTES  byte selects from master N.
REQ-010 mN_dat_sm  out  8*DATA_BYTES  read data to master N.
REQ-011 mN_ack, mN_err  out  1 each  acknowledge and error to master N.
REQ-012 s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel  out  as master  request to the SDRAM slave.
REQ-013 s_dat_sm, s_ack, s_err  in  as master  response from the SDRAM slave.
REQ-014 grant  out  2  one-hot current owner; 2'b00 when idle.

Function
REQ-015 The FSM SHALL have states IDLE, GNT0 and GNT1, with a registered grant equal to {state==GNT1, state==GNT0}.
REQ-016 A register last SHALL hold the most recent owner (0 or 1).
REQ-017 From IDLE, if exactly one mN_cyc is high, the FSM SHALL move to GNTN at the next edge.
REQ-018 From IDLE, if both mN_cyc are high, the FSM SHALL grant the master that is not equal to last (round-robin).
REQ-019 In GNTN, while mN_cyc is high and no timeout occurs, the FSM SHALL hold GNTN regardless of the other master (bursts are never split).
REQ-020 In GNTN, when mN_cyc is low and the other master's cyc is high, the FSM SHALL hand over directly to the other GNT state with no IDLE cycle; otherwise it SHALL return to IDLE.
REQ-021 On leaving GNTN, last SHALL be set to N.
REQ-022 In GNTN, the s_cyc, s_stb, s_we, s_adr, s_dat_ms and s_sel outputs SHALL be combinational copies of master N's signals.
REQ-023 In GNTN, mN_ack SHALL equal s_ack and mN_err SHALL equal s_err; the non-owner's ack and err SHALL be 0.
REQ-024 In IDLE, s_cyc and s_stb SHALL be 0 and both masters' ack and err SHALL be 0.
REQ-025 Both mN_dat_sm outputs SHALL be driven by s_dat_sm unconditionally; they are valid only with mN_ack.
REQ-026 Arbitration latency SHALL be exactly one cycle: a request from IDLE appears on s_cyc on the cycle after mN_cyc rises.
REQ-027 A watchdog counter (width $clog2(TIMEOUT+1)) SHALL increment while the owner has s_stb=1 and s_ack=s_err=0.
REQ-028 The watchdog counter SHALL clear on s_ack, on s_err, on s_stb=0, and on any state change.
REQ-029 When the counter equals TIMEOUT, in that same cycle: mN_err=1, s_cyc=s_stb=0, and the FSM leaves GNTN as in REQ-020 (handover if the other master is requesting, else IDLE), with last=N.
REQ-030 A timed-out master still holding cyc SHALL be treated as a fresh request, subject to round-robin.
REQ-031 A slave ack arriving in the timeout cycle SHALL take precedence: the counter clears, no err is issued, and the grant is kept.

Reset
REQ-032 While sys_rst=1: state=IDLE, last=1 (so master 0 wins the first contention), counter=0, grant=00, s_cyc=s_stb=0, and all mN_ack and mN_err=0.
REQ-033 Reset asserted mid-transfer SHALL abort it in the same cycle the state is cleared; no ack or err SHALL be forwarded after the reset edge.

Verification
REQ-034 Single master: m0 reads 4 words at 0x100..0x10C with the slave acking every cycle -> s_cyc rises 1 cycle after m0_cyc; 4 m0_ack; grant 01 then 00; m1_ack=0 throughout.
REQ-035 Contention after reset: m0_cyc and m1_cyc rise on the same cycle -> GNT0 first; when m0 drops cyc, GNT1 follows with no IDLE cycle; a second simultaneous request then goes to m1 only if last=0, i.e. m1 is granted next only if m0 was the last owner.
REQ-036 Burst hold: m1 holds cyc for 16 acked beats while m0 requests throughout -> grant stays 10 for all 16 beats, then switches to 01.
REQ-037 Timeout: TIMEOUT=8 and the slave never acks m0 -> m0_err=1 exactly in the 9th stb cycle with s_cyc=0 in that cycle; a pending m1 is granted on the next cycle.
REQ-038 Ack on the boundary: with TIMEOUT=8, the slave acks on the cycle the counter reaches 8 -> m0_ack=1, m0_err=0, grant unchanged.
REQ-039 Reset mid-burst: sys_rst pulses for 1 cycle during a granted m1 burst -> grant=00 and s_cyc=0 on the next cycle; m1_ack=0 afterwards until regranted.
